perf_monitor: RTL
=================

PERF_MONITOR -- requirements
Module: perf_monitor

Interface
REQ-001 Parameter NUM_EVENTS, default 2, number of event counter channels (1..16).
REQ-002 Parameter CNT_W, default 32, width of every counter (4..64).
REQ-003 Parameter MAX_CYCLES, default 64, run-length cycle limit; 0 = unlimited.
REQ-004 Parameter SATURATE, default 0; 0 = counters wrap, 1 = counters saturate at all-ones.
REQ-005 One clock; reset is asynchronous and active-high: clk_i  input  1  clock, all state on rising edge.
REQ-006 rst_i  input  1  asynchronous active-high reset.
REQ-007 start_i  input  1  run enable; counting permitted while high.
REQ-008 clr_i  input  1  synchronous clear of live counters, overflow flags and done.
REQ-009 event_i  input  NUM_EVENTS  per-cycle event strobes (e.g. stall, flush); bit k feeds counter k.
REQ-010 snap_i  input  1  copy live counters into shadow bank.
REQ-011 rd_idx_i  input  clog2(NUM_EVENTS+1)  shadow read select: 0 = cycle, k = event k-1.
REQ-012 rd_data_o  output  CNT_W  registered shadow read data.
REQ-013 cycle_o  output  CNT_W  live cycle counter.
REQ-014 done_o  output  1  high in DONE state.
REQ-015 ovf_o  output  NUM_EVENTS+1  sticky overflow flags; bit 0 = cycle, bit k = event k-1.

Function
REQ-016 FSM states IDLE, RUN, DONE; DONE reachable only when MAX_CYCLES != 0.
REQ-017 IDLE -> RUN on an edge with start_i=1; no counting on that edge.
REQ-018 RUN: every edge increments cycle counter; event counter k increments when event_i[k]=1 on that edge.
REQ-019 RUN -> IDLE on an edge with start_i=0; counting suppressed on that edge, all counts held.
REQ-020 RUN -> DONE on the edge where the cycle counter becomes MAX_CYCLES; that edge's events are counted.
REQ-021 DONE holds all counters, ignores start_i and event_i; leaves only via clr_i or rst_i.
REQ-022 clr_i has priority over all transitions: live counters and ovf_o to 0, state to IDLE, same edge.
REQ-023 Overflow, SATURATE=0: counter at all-ones plus increment wraps to 0 and sets its ovf_o bit.
REQ-024 Overflow, SATURATE=1: counter at all-ones holds all-ones and sets its ovf_o bit on the attempted increment.
REQ-025 ovf_o bits remain set until clr_i or rst_i.
REQ-026 snap_i captures the counter values present before that edge's update (pre-increment, pre-clear).
REQ-027 snap_i together with clr_i: shadow receives pre-clear values; live counters cleared.
REQ-028 snap_i permitted in any state; shadow unaffected by clr_i.
REQ-029 rd_data_o updates every edge from shadow[rd_idx_i] as held before that edge: 1-cycle latency; snap_i and read on the same edge return the old shadow.
REQ-030 rd_idx_i > NUM_EVENTS yields rd_data_o = 0.
REQ-031 Unused rd_idx_i codes, X-free: no output ever depends on uninitialised storage.

Reset
REQ-032 rst_i=1 forces, asynchronously: state IDLE, all live and shadow counters 0, rd_data_o=0, cycle_o=0, done_o=0, ovf_o=0.
REQ-033 Reset mid-RUN discards all counts; first edge after release with start_i=1 enters RUN without counting.

Verification (NUM_EVENTS=2, CNT_W=8, MAX_CYCLES=64, SATURATE=0 unless stated)
REQ-034 Release reset, start_i=1 constant, event_i[0]=1 on cycles 5..14 -> done_o rises with cycle_o=64, event 0 count=10, then counts frozen 20 further cycles.
REQ-035 start_i low for 3 edges mid-run with event_i=2'b11 -> cycle and event counts unchanged across the pause, resume continues from held values.
REQ-036 MAX_CYCLES=0, CNT_W=4, run 17 edges -> cycle_o=0 after 16, then 1; ovf_o[0]=1 sticky; SATURATE=1 run -> cycle_o=15, ovf_o[0]=1.
REQ-037 snap_i and clr_i together at cycle count 30 -> next cycle rd_idx_i=0 gives rd_data_o=30, cycle_o=0, state IDLE.
REQ-038 snap_i with rd_idx_i=1 same edge after prior snapshot 7, live 12 -> rd_data_o=7 that cycle, 12 one cycle later; rd_idx_i=3 -> 0.
REQ-039 rst_i asserted asynchronously mid-RUN between edges -> all outputs 0 immediately, before next clock edge.

Source files
------------

// File: rtl/perf_monitor_if.sv
// perf_monitor_if: control, event and readback signals of perf_monitor.
//   start_i   run enable
//   clr_i     synchronous clear of live counters, overflow flags and done
//   event_i   per-cycle event strobes, bit k feeds event counter k
//   snap_i    copy live counters into the shadow bank
//   rd_idx_i  shadow read select (0 = cycle, k = event k-1)
//   rd_data_o registered shadow read data
//   cycle_o   live cycle counter
//   done_o    high while the run limit has been reached
//   ovf_o     sticky overflow flags (bit 0 = cycle, bit k = event k-1)
interface perf_monitor_if #(
  parameter int unsigned NUM_EVENTS = 2,
  parameter int unsigned CNT_W      = 32
) ();
  localparam int unsigned IDX_W = $clog2(NUM_EVENTS + 1);

  logic                  start_i;
  logic                  clr_i;
  logic [NUM_EVENTS-1:0] event_i;
  logic                  snap_i;
  logic [IDX_W-1:0]      rd_idx_i;
  logic [CNT_W-1:0]      rd_data_o;
  logic [CNT_W-1:0]      cycle_o;
  logic                  done_o;
  logic [NUM_EVENTS:0]   ovf_o;

  modport master (
    output start_i, clr_i, event_i, snap_i, rd_idx_i,
    input  rd_data_o, cycle_o, done_o, ovf_o
  );

  modport slave (
    input  start_i, clr_i, event_i, snap_i, rd_idx_i,
    output rd_data_o, cycle_o, done_o, ovf_o
  );
endinterface

// File: rtl/perf_monitor.sv
// perf_monitor: run-length limited cycle counter plus NUM_EVENTS event
// counters, with a snapshot (shadow) bank and a registered readback port.
//   clk_i  clock, all state on rising edge
//   rst_i  asynchronous active-high reset
//   bus    perf_monitor_if.slave (start/clr/event/snap/rd_idx in,
//          rd_data/cycle/done/ovf out)
// Counter index 0 is the cycle counter, index k is event k-1.
module perf_monitor #(
  parameter int unsigned NUM_EVENTS = 2,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned MAX_CYCLES = 64,
  parameter bit          SATURATE   = 1'b0
) (
  input logic           clk_i,
  input logic           rst_i,
  perf_monitor_if.slave bus
);
  localparam int unsigned NCNT  = NUM_EVENTS + 1;
  localparam int unsigned IDX_W = $clog2(NUM_EVENTS + 1);
  // Limit compared at 65 bits so a limit beyond the counter range never matches.
  localparam logic [64:0] LIMIT = 65'(MAX_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt     [NCNT];
  logic [CNT_W-1:0] cnt_nxt [NCNT];
  logic [CNT_W-1:0] shadow  [NCNT];
  logic [NCNT-1:0]  ovf, ovf_nxt;
  logic [NCNT-1:0]  inc;
  logic [CNT_W-1:0] rd_sel;
  logic [CNT_W-1:0] rd_data;
  logic             count_en;
  logic             limit_hit;
  logic             done;

  // Counting only happens on RUN edges that stay in RUN (start held, no clear).
  always_comb begin
    count_en = (state == RUN) && bus.start_i && !bus.clr_i;
    inc      = '0;
    inc[0]   = count_en;
    for (int unsigned k = 0; k < NUM_EVENTS; k++) begin
      inc[k+1] = count_en && bus.event_i[k];
    end
  end

  // Next counter values and sticky overflow flags.
  always_comb begin
    ovf_nxt = ovf;
    for (int unsigned k = 0; k < NCNT; k++) begin
      cnt_nxt[k] = cnt[k];
      if (bus.clr_i) begin
        cnt_nxt[k] = '0;
        ovf_nxt[k] = 1'b0;
      end else if (inc[k]) begin
        if (cnt[k] == '1) begin
          ovf_nxt[k] = 1'b1;
          cnt_nxt[k] = SATURATE ? cnt[k] : '0;
        end else begin
          cnt_nxt[k] = cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  assign limit_hit = (MAX_CYCLES != 0) && (65'(cnt_nxt[0]) == LIMIT);

  // FSM: state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state (clear overrides every transition)
  always_comb begin
    state_nxt = state;
    if (bus.clr_i) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: if (bus.start_i) state_nxt = RUN;
        RUN: begin
          if (!bus.start_i) begin
            state_nxt = IDLE;
          end else if (limit_hit) begin
            state_nxt = DONE;
          end
        end
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    done = (state == DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < NCNT; k++) begin
        cnt[k] <= '0;
      end
      ovf <= '0;
    end else begin
      for (int unsigned k = 0; k < NCNT; k++) begin
        cnt[k] <= cnt_nxt[k];
      end
      ovf <= ovf_nxt;
    end
  end

  // Shadow takes the pre-update (pre-increment, pre-clear) live values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < NCNT; k++) begin
        shadow[k] <= '0;
      end
    end else if (bus.snap_i) begin
      for (int unsigned k = 0; k < NCNT; k++) begin
        shadow[k] <= cnt[k];
      end
    end
  end

  // Read select; codes above NUM_EVENTS fall through to zero.
  always_comb begin
    rd_sel = '0;
    for (int unsigned k = 0; k < NCNT; k++) begin
      if (bus.rd_idx_i == IDX_W'(k)) begin
        rd_sel = shadow[k];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_sel;
    end
  end

  assign bus.rd_data_o = rd_data;
  assign bus.cycle_o   = cnt[0];
  assign bus.done_o    = done;
  assign bus.ovf_o     = ovf;
endmodule
